// File: rtl/jtag_dtm_tap.sv
// JTAG TAP controller plus RISC-V Debug Transport Module responder.
// JTAG pins are oversampled in the clk domain; DMI scans become valid/ready requests.
module jtag_dtm_tap #(
  parameter logic [31:0] IDCODE      = 32'h1e200a6d,
  parameter logic [2:0]  IDLE_CYCLES = 3'd5,
  parameter int unsigned DMI_ABITS   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 jtag_tck,
  input  logic                 jtag_tms,
  input  logic                 jtag_tdi,
  output logic                 jtag_tdo,
  output logic                 dmi_req_valid,
  input  logic                 dmi_req_ready,
  output logic [DMI_ABITS-1:0] dmi_req_addr,
  output logic [31:0]          dmi_req_data,
  output logic [1:0]           dmi_req_op,
  input  logic                 dmi_resp_valid,
  input  logic [31:0]          dmi_resp_data
);

  localparam int unsigned DmiW       = DMI_ABITS + 34;
  localparam logic [5:0]  AbitsField = 6'(DMI_ABITS);
  localparam logic [4:0]  IrIdcode   = 5'h01;
  localparam logic [4:0]  IrDtmcs    = 5'h10;
  localparam logic [4:0]  IrDmi      = 5'h11;

  typedef enum logic [3:0] {
    StTlr, StRti, StSelDr, StCapDr, StShiftDr, StExit1Dr, StPauseDr, StExit2Dr, StUpdDr,
    StSelIr, StCapIr, StShiftIr, StExit1Ir, StPauseIr, StExit2Ir, StUpdIr
  } tap_state_e;

  logic                 tck_q1, tck_q2, tck_q3, tms_q1, tms_q2, tdi_q1, tdi_q2;
  logic                 tck_rise, tck_fall;
  tap_state_e           tap_q, tap_d;
  logic [4:0]           ir_q, ir_sr_q;
  logic [DmiW-1:0]      dr_q, dr_cap, dr_shift;
  logic [31:0]          resp_q, dtmcs_cap;
  logic                 busy_q, err_q, tdo_q, req_valid_q;
  logic [DMI_ABITS-1:0] req_addr_q;
  logic [31:0]          req_data_q;
  logic [1:0]           req_op_q, dmistat, dmi_status;
  logic                 upd_is_req;

  assign tck_rise   = tck_q2 & ~tck_q3;
  assign tck_fall   = ~tck_q2 & tck_q3;
  assign dmistat    = err_q ? 2'b11 : 2'b00;
  assign dmi_status = (busy_q | err_q) ? 2'b11 : 2'b00;
  assign dtmcs_cap  = {17'b0, IDLE_CYCLES, dmistat, AbitsField, 4'h1};
  assign upd_is_req = (dr_q[1:0] == 2'b01) || (dr_q[1:0] == 2'b10);

  always_comb begin
    tap_d = tap_q;
    case (tap_q)
      StTlr:     tap_d = tms_q2 ? StTlr     : StRti;
      StRti:     tap_d = tms_q2 ? StSelDr   : StRti;
      StSelDr:   tap_d = tms_q2 ? StSelIr   : StCapDr;
      StCapDr:   tap_d = tms_q2 ? StExit1Dr : StShiftDr;
      StShiftDr: tap_d = tms_q2 ? StExit1Dr : StShiftDr;
      StExit1Dr: tap_d = tms_q2 ? StUpdDr   : StPauseDr;
      StPauseDr: tap_d = tms_q2 ? StExit2Dr : StPauseDr;
      StExit2Dr: tap_d = tms_q2 ? StUpdDr   : StShiftDr;
      StUpdDr:   tap_d = tms_q2 ? StSelDr   : StRti;
      StSelIr:   tap_d = tms_q2 ? StTlr     : StCapIr;
      StCapIr:   tap_d = tms_q2 ? StExit1Ir : StShiftIr;
      StShiftIr: tap_d = tms_q2 ? StExit1Ir : StShiftIr;
      StExit1Ir: tap_d = tms_q2 ? StUpdIr   : StPauseIr;
      StPauseIr: tap_d = tms_q2 ? StExit2Ir : StPauseIr;
      StExit2Ir: tap_d = tms_q2 ? StUpdIr   : StShiftIr;
      StUpdIr:   tap_d = tms_q2 ? StSelDr   : StRti;
      default:   tap_d = StTlr;
    endcase
  end

  // One physical shift register serves every DR; tdi enters at the selected length's MSB.
  always_comb begin
    dr_cap   = '0;
    dr_shift = '0;
    case (ir_q)
      IrIdcode: begin
        dr_cap             = DmiW'(IDCODE);
        dr_shift[31:0]     = {tdi_q2, dr_q[31:1]};
      end
      IrDtmcs: begin
        dr_cap             = DmiW'(dtmcs_cap);
        dr_shift[31:0]     = {tdi_q2, dr_q[31:1]};
      end
      IrDmi: begin
        dr_cap             = {req_addr_q, resp_q, dmi_status};
        dr_shift           = {tdi_q2, dr_q[DmiW-1:1]};
      end
      default: dr_shift[0] = tdi_q2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      {tck_q1, tck_q2, tck_q3, tms_q1, tms_q2, tdi_q1, tdi_q2} <= '0;
      tap_q       <= StTlr;
      ir_q        <= IrIdcode;
      ir_sr_q     <= '0;
      dr_q        <= '0;
      resp_q      <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      tdo_q       <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_op_q    <= '0;
    end else begin
      {tck_q1, tck_q2, tck_q3} <= {jtag_tck, tck_q1, tck_q2};
      {tms_q1, tms_q2}         <= {jtag_tms, tms_q1};
      {tdi_q1, tdi_q2}         <= {jtag_tdi, tdi_q1};

      if (req_valid_q && dmi_req_ready) req_valid_q <= 1'b0;
      if (dmi_resp_valid) begin
        resp_q <= dmi_resp_data;
        busy_q <= 1'b0;
      end

      if (tck_fall && tap_q == StShiftIr) tdo_q <= ir_sr_q[0];
      if (tck_fall && tap_q == StShiftDr) tdo_q <= dr_q[0];

      // Actions follow the state being left; later assignments override the handshake above.
      if (tck_rise) begin
        tap_q <= tap_d;
        if (tap_d == StTlr) ir_q <= IrIdcode;
        case (tap_q)
          StCapIr:   ir_sr_q <= 5'b00001;
          StShiftIr: ir_sr_q <= {tdi_q2, ir_sr_q[4:1]};
          StUpdIr:   ir_q    <= ir_sr_q;
          StCapDr:   dr_q    <= dr_cap;
          StShiftDr: dr_q    <= dr_shift;
          StUpdDr: begin
            if (ir_q == IrDtmcs) begin
              if (dr_q[16] || dr_q[17]) err_q <= 1'b0;
              if (dr_q[17]) begin
                req_valid_q <= 1'b0;
                busy_q      <= 1'b0;
              end
            end else if (ir_q == IrDmi && upd_is_req) begin
              if (busy_q) begin
                err_q <= 1'b1;
              end else if (!err_q) begin
                req_valid_q <= 1'b1;
                busy_q      <= 1'b1;
                req_addr_q  <= dr_q[DmiW-1:34];
                req_data_q  <= dr_q[33:2];
                req_op_q    <= dr_q[1:0];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign jtag_tdo      = tdo_q;
  assign dmi_req_valid = req_valid_q;
  assign dmi_req_addr  = req_addr_q;
  assign dmi_req_data  = req_data_q;
  assign dmi_req_op    = req_op_q;

endmodule

// File: tb/tb_jtag_dtm_tap.sv
// Self-checking bench for jtag_dtm_tap: directed plan vectors, corner sequences,
// and random DMI/DTMCS/BYPASS traffic against a transaction-level DTM model.
module tb_jtag_dtm_tap;

  logic        clk = 1'b0, rst = 1'b0;
  logic        tck = 1'b0, tms = 1'b0, tdi = 1'b0, tdo;
  logic        req_valid, req_ready = 1'b0;
  logic [5:0]  req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_op;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model of the DTM's visible state
  logic        m_busy, m_err, m_pending;
  logic [31:0] m_resp;
  logic [5:0]  m_last_addr;

  jtag_dtm_tap dut (
    .clk           (clk),
    .rst           (rst),
    .jtag_tck      (tck),
    .jtag_tms      (tms),
    .jtag_tdi      (tdi),
    .jtag_tdo      (tdo),
    .dmi_req_valid (req_valid),
    .dmi_req_ready (req_ready),
    .dmi_req_addr  (req_addr),
    .dmi_req_data  (req_data),
    .dmi_req_op    (req_op),
    .dmi_resp_valid(resp_valid),
    .dmi_resp_data (resp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One TCK period, 5 clk per phase; TDO is sampled just before the rising edge.
  task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
    tms = tms_v;
    tdi = tdi_v;
    wait_clk(5);
    tdo_v = tdo;
    tck = 1'b1;
    wait_clk(5);
    tck = 1'b0;
  endtask

  task automatic tms_step(input logic v);
    logic dmy;
    tck_cycle(v, 1'b0, dmy);
  endtask

  // Both scans start and end in Run-Test/Idle.
  task automatic scan_ir(input logic [4:0] ir, output logic [4:0] cap);
    logic b;
    tms_step(1'b1); tms_step(1'b1); tms_step(1'b0); tms_step(1'b0);
    for (int i = 0; i < 5; i++) begin
      tck_cycle(i == 4, ir[i], b);
      cap[i] = b;
    end
    tms_step(1'b1); tms_step(1'b0);
  endtask

  task automatic scan_dr(input int len, input logic [63:0] din, output logic [63:0] dout);
    logic b;
    dout = '0;
    tms_step(1'b1); tms_step(1'b0); tms_step(1'b0);
    for (int i = 0; i < len; i++) begin
      tck_cycle(i == len - 1, din[i], b);
      dout[i] = b;
    end
    tms_step(1'b1); tms_step(1'b0);
  endtask

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_pending = 0; m_resp = '0; m_last_addr = '0;
  endtask

  function automatic logic [63:0] exp_dmi();
    return (64'(m_last_addr) << 34) | (64'(m_resp) << 2) | ((m_busy || m_err) ? 64'd3 : 64'd0);
  endfunction

  function automatic logic [63:0] exp_dtmcs();
    return 64'h5061 | (m_err ? 64'hc00 : 64'h0);
  endfunction

  task automatic dmi_scan(input logic [5:0] a, input logic [31:0] d, input logic [1:0] op,
                          output logic issue, output logic [63:0] o);
    logic [4:0]  c;
    logic [63:0] e;
    scan_ir(5'h11, c);
    check("dmi_ir_capture", 64'(c), 64'h1);
    e = exp_dmi();
    scan_dr(40, {24'h0, a, d, op}, o);
    check("dmi_capture", o, e);
    issue = 1'b0;
    if (op == 2'd1 || op == 2'd2) begin
      if (m_busy) m_err = 1'b1;
      else if (!m_err) begin
        issue = 1'b1; m_busy = 1'b1; m_pending = 1'b1; m_last_addr = a;
      end
    end
    check("dmi_req_valid", 64'(req_valid), 64'(m_pending));
    if (issue) begin
      check("dmi_req_addr", 64'(req_addr), 64'(a));
      check("dmi_req_data", 64'(req_data), 64'(d));
      check("dmi_req_op", 64'(req_op), 64'(op));
    end
  endtask

  task automatic dtmcs_scan(input logic [31:0] din, output logic [63:0] o);
    logic [4:0]  c;
    logic [63:0] e;
    scan_ir(5'h10, c);
    check("dtmcs_ir_capture", 64'(c), 64'h1);
    e = exp_dtmcs();
    scan_dr(32, 64'(din), o);
    check("dtmcs_capture", o, e);
    if (din[16] || din[17]) m_err = 1'b0;
    if (din[17]) begin
      m_busy = 1'b0; m_pending = 1'b0;
    end
    check("valid_after_dtmcs", 64'(req_valid), 64'(m_pending));
  endtask

  task automatic accept();
    req_ready = 1'b1;
    wait_clk(1);
    req_ready = 1'b0;
    m_pending = 1'b0;
    check("valid_drop_after_ready", 64'(req_valid), 64'h0);
  endtask

  task automatic respond(input logic [31:0] d);
    resp_valid = 1'b1;
    resp_data  = d;
    wait_clk(1);
    resp_valid = 1'b0;
    wait_clk(1);
    m_resp = d; m_busy = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  ir;
    int          len;
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs[5];
  logic [4:0]  cap, rir;
  logic [63:0] o;
  logic        iss;
  logic [5:0]  ra;
  logic [31:0] rd, rw;
  logic [1:0]  rop;
  logic [7:0]  rb;
  int unsigned sel;

  initial begin
    vecs[0] = '{5'h01, 32, 64'h0,   64'h1e200a6d};
    vecs[1] = '{5'h10, 32, 64'h0,   64'h00005061};
    vecs[2] = '{5'h1f, 8,  64'ha5,  64'h4a};
    vecs[3] = '{5'h00, 8,  64'h3c,  64'h78};
    vecs[4] = '{5'h12, 8,  64'h81,  64'h02};
    model_reset();

    // Reset state
    wait_clk(4);
    check("reset_tdo", 64'(tdo), 64'h0);
    check("reset_valid", 64'(req_valid), 64'h0);
    check("reset_addr", 64'(req_addr), 64'h0);
    check("reset_data", 64'(req_data), 64'h0);
    check("reset_op", 64'(req_op), 64'h0);
    rst = 1'b1;
    wait_clk(2);

    for (int i = 0; i < 8; i++) tms_step(1'b1);
    check("tlr_tdo", 64'(tdo), 64'h0);
    check("tlr_valid", 64'(req_valid), 64'h0);
    tms_step(1'b0);
    scan_dr(32, 64'h0, o);
    check("idcode_after_tlr", o, 64'h1e200a6d);

    // Table-driven IR/DR vectors
    for (int i = 0; i < 5; i++) begin
      scan_ir(vecs[i].ir, cap);
      check("vec_ir_capture", 64'(cap), 64'h1);
      scan_dr(vecs[i].len, vecs[i].din, o);
      check("vec_dr_out", o, vecs[i].exp);
    end

    // DMI write held off by ready for 5 clk
    dmi_scan(6'h10, 32'h0, 2'd2, iss, o);
    check("wr_issued", 64'(iss), 64'h1);
    for (int i = 0; i < 5; i++) begin
      wait_clk(1);
      check("wr_hold_valid", 64'(req_valid), 64'h1);
      check("wr_hold_fields", {req_addr, req_data, req_op}, {6'h10, 32'h0, 2'd2});
    end
    accept();
    respond(32'h0);

    // DMI read and response readback
    dmi_scan(6'h11, 32'h0, 2'd1, iss, o);
    accept();
    respond(32'h00030382);
    dmi_scan(6'h0, 32'h0, 2'd0, iss, o);
    check("rd_back_data", 64'(o[33:2]), 64'h00030382);
    check("rd_back_addr", 64'(o[39:34]), 64'h11);
    check("rd_back_status", 64'(o[1:0]), 64'h0);
    dmi_scan(6'h3f, 32'hffffffff, 2'd3, iss, o);
    check("op3_no_req", 64'(req_valid), 64'h0);

    // Busy: second request before a response sets the sticky error
    dmi_scan(6'h20, 32'hdeadbeef, 2'd2, iss, o);
    accept();
    dmi_scan(6'h21, 32'h1234, 2'd2, iss, o);
    check("busy_no_req", 64'(req_valid), 64'h0);
    dmi_scan(6'h0, 32'h0, 2'd0, iss, o);
    check("busy_status", 64'(o[1:0]), 64'h3);
    dtmcs_scan(32'h00010000, o);
    check("dtmcs_err", o, 64'h5c61);
    dtmcs_scan(32'h0, o);
    check("dtmcs_cleared", o, 64'h5061);
    respond(32'hcafef00d);

    // dmihardreset drops an unaccepted request
    dmi_scan(6'h05, 32'h55aa55aa, 2'd1, iss, o);
    dtmcs_scan(32'h00020000, o);
    check("hardreset_valid", 64'(req_valid), 64'h0);
    dmi_scan(6'h0, 32'h0, 2'd0, iss, o);
    check("hardreset_status", 64'(o[1:0]), 64'h0);

    // TAP reset from mid-scan leaves an in-flight request untouched
    dmi_scan(6'h2a, 32'h0badf00d, 2'd2, iss, o);
    scan_ir(5'h1f, cap);
    tms_step(1'b1); tms_step(1'b0); tms_step(1'b0);
    for (int i = 0; i < 3; i++) tms_step(1'b0);
    for (int i = 0; i < 5; i++) tms_step(1'b1);
    tms_step(1'b0);
    check("tapreset_valid", 64'(req_valid), 64'h1);
    check("tapreset_addr", 64'(req_addr), 64'h2a);
    scan_dr(32, 64'h0, o);
    check("tapreset_idcode", o, 64'h1e200a6d);
    accept();
    respond(32'h77);

    // System reset mid-request
    dmi_scan(6'h33, 32'h13572468, 2'd1, iss, o);
    rst = 1'b0;
    wait_clk(2);
    check("midrst_valid", 64'(req_valid), 64'h0);
    check("midrst_fields", {req_addr, req_data, req_op}, 64'h0);
    check("midrst_tdo", 64'(tdo), 64'h0);
    rst = 1'b1;
    model_reset();
    wait_clk(10);
    check("midrst_no_reissue", 64'(req_valid), 64'h0);
    tms_step(1'b0);
    dmi_scan(6'h0, 32'h0, 2'd0, iss, o);
    check("midrst_dmi_clear", o, 64'h0);

    // Random traffic against the model
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0, 1: begin
          ra  = 6'($urandom);
          rd  = $urandom;
          rop = 2'($urandom_range(0, 3));
          dmi_scan(ra, rd, rop, iss, o);
          if (iss) begin
            accept();
            if ($urandom_range(0, 1) == 1) respond($urandom);
          end
        end
        2: if (m_busy) respond($urandom);
        3: begin
          rw     = $urandom;
          rw[17] = ($urandom_range(0, 3) == 0);
          rw[16] = 1'($urandom_range(0, 1));
          dtmcs_scan(rw, o);
        end
        default: begin
          rir = 5'($urandom);
          while (rir == 5'h01 || rir == 5'h10 || rir == 5'h11) rir = 5'($urandom);
          rb = 8'($urandom);
          scan_ir(rir, cap);
          check("rand_bypass_ir", 64'(cap), 64'h1);
          scan_dr(8, 64'(rb), o);
          check("rand_bypass", o, 64'({rb[6:0], 1'b0}));
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_dtm_tap.md
Name: jtag_dtm_tap

Overview:
- JTAG TAP plus Debug Transport Module (DTM) responder. It is the target side of the TCK/TMS/TDI/TDO host sequences used to drive the SoC in simulation.
- Oversamples the JTAG pins in the clk domain and runs the 16-state IEEE 1149.1 TAP controller. Implements IR, IDCODE, DTMCS, DMI and BYPASS registers.
- Converts DMI scans into a valid/ready request toward the debug module, and captures its response.

Parameters:
- IDCODE, 32'h1e200a6d, value captured in the IDCODE data register.
- IDLE_CYCLES, 3'd5, value reported in DTMCS.idle.
- DMI_ABITS, 6, DMI address width; the DMI register is DMI_ABITS+34 bits wide.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-low reset.
- jtag_tck  in  1  JTAG clock, asynchronous; sampled as data.
- jtag_tms  in  1  JTAG mode select, asynchronous.
- jtag_tdi  in  1  JTAG data in, asynchronous.
- jtag_tdo  out  1  JTAG data out.
- dmi_req_valid  out  1  DMI request valid.
- dmi_req_ready  in  1  DM accepts the request.
- dmi_req_addr  out  DMI_ABITS  request address.
- dmi_req_data  out  32  write data.
- dmi_req_op  out  2  request op: 1 = read, 2 = write.
- dmi_resp_valid  in  1  DM response valid, one-cycle pulse; always accepted.
- dmi_resp_data  in  32  response data.

Behaviour:
- Reset (rst==0 at a clk edge):
  - TAP state = TEST_LOGIC_RESET; IR = 5'h01; all shift registers 0.
  - jtag_tdo = 0; dmi_req_valid = 0; addr/data/op = 0.
  - Response latch = 0; busy = 0; sticky error = 0.
- Pin sampling:
  - tck, tms and tdi each pass through a 2-flop synchronizer. A third tck flop provides edge detection.
  - rise = sync==1 && prev==0; fall = sync==0 && prev==1.
  - Each TCK high and low phase must last >= 4 clk.
- On rise, the TAP advances per the standard 1149.1 TMS table.
  - Five consecutive rises with TMS=1 reach TEST_LOGIC_RESET from any state.
  - Entering TEST_LOGIC_RESET sets IR = 5'h01.
- IR (5 bits):
  - CAPTURE_IR loads 5'b00001.
  - SHIFT_IR shifts LSB first: sr <= {tdi, sr[4:1]}.
  - UPDATE_IR copies sr to IR.
- DR selection by IR:
  - 5'h01 IDCODE (32 bits).
  - 5'h10 DTMCS (32 bits).
  - 5'h11 DMI (40 bits).
  - Any other value selects BYPASS (1 bit; captures 0).
- DR shifting:
  - SHIFT_DR shifts LSB first; tdi enters the MSB of the selected length.
  - Shifting only on SHIFT states at rise; the capture/update action happens on the rise that leaves CAPTURE/UPDATE state.
- DTMCS:
  - Capture value: {14'b0, 1'b0, 1'b0, 1'b0, IDLE_CYCLES, dmistat[1:0], DMI_ABITS[5:0], 4'h1}.
  - dmistat = 2'b11 if the sticky error is set, else 2'b00.
  - Update-DR with bit16 (dmireset) or bit17 (dmihardreset) set clears the sticky error. Bit17 additionally drops any outstanding request: dmi_req_valid=0, busy=0.
- DMI register format: {addr[5:0], data[31:0], op[1:0]}.
  - Capture value: {last_addr, resp_data_latch, status}.
  - status = 2'b11 if busy or sticky error is set, else 2'b00.
- DMI Update-DR:
  - If op is 1 or 2, busy==0 and no sticky error: drive addr/data/op, set dmi_req_valid=1 and busy=1.
  - If op is 1 or 2 while busy==1: set the sticky error and issue no request.
  - op 0 or 3: no request.
- Request handshake:
  - dmi_req_valid holds with stable addr/data/op until a clk cycle where dmi_req_ready==1; it deasserts on the next clk.
  - On dmi_resp_valid: latch dmi_resp_data and clear busy.
  - Valid/ready acceptance and a response in the same cycle are legal; busy clears.
- TDO:
  - On fall, in SHIFT_IR or SHIFT_DR, jtag_tdo <= sr[0] of the active register. Otherwise jtag_tdo holds.
  - TDO therefore changes on the falling edge and is stable before the next rise.
- Reset mid-operation:
  - rst==0 aborts any scan and any outstanding request immediately.
  - No request is re-issued after reset.
- TAP reset (TEST_LOGIC_RESET) does not affect an in-flight DMI request.

Test Plan:
- Reset, then 8 TCK with TMS=1 -> IR=5'h01, TAP in TEST_LOGIC_RESET, jtag_tdo=0, dmi_req_valid=0.
- IR scan shifting in 5'h11 -> the 5 TDO bits read 1,0,0,0,0 (captured 5'b00001); IR=5'h11 after UPDATE_IR.
- IDCODE DR scan of 32 bits -> TDO stream equals 32'h1e200a6d LSB first. DTMCS scan -> 32'h00005061.
- DMI write: shift {6'h10, 32'h0, 2'b10}, then UPDATE_DR -> dmi_req_valid=1 with addr=0x10, data=0, op=2. Hold dmi_req_ready=0 for 5 clk -> outputs stable; then ready=1 for 1 clk -> valid drops next clk.
- DMI read of 0x11 (op=1), DM responds 32'h00030382 -> the next DMI scan (op=0) shifts out data=0x00030382, status=0, addr=0x11.
- Busy handling: new op=2 Update-DR before any response arrives -> no request; next DMI capture status=3 and DTMCS dmistat=3. DTMCS write with bit16 set -> dmistat=0.
